// File: rtl/fir_eq_pkg.sv
// Shared types, width helpers and the output fit function for the FIR equaliser.
// FIR_EQ_SAT_EN selects saturating (defined) or wrapping (undefined) output fit.
package fir_eq_pkg;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_GAIN, S_OUT} state_e;

    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    function automatic int total_width(input int dw, input int cw, input int ntaps,
                                       input int gw, input int nbands);
        return acc_width(dw, cw, ntaps) + gw + 1 + $clog2(nbands) + 1;
    endfunction

    // Operates on a 64-bit sign-extended value; the band sum must fit in 64 bits.
    function automatic logic signed [63:0] fit_val(input logic signed [63:0] v, input int ow);
`ifdef FIR_EQ_SAT_EN
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - ow)) >>> (64 - ow);
`endif
    endfunction

`ifdef FIR_EQ_SAT_EN
    function automatic logic fit_clip(input logic signed [63:0] v, input int ow);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        return (v > hi) || (v < lo);
    endfunction
`endif

endpackage

// File: rtl/fir_eq_ring.sv
// NTAPS-deep circular sample window; read returns x[n-tap] relative to the newest write.
module fir_eq_ring #(
    parameter int DW    = 16,
    parameter int NTAPS = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(NTAPS)-1:0] tap_i,
    output logic [DW-1:0]            rdata_o
);
    localparam int PW = $clog2(NTAPS);

    logic [NTAPS-1:0][DW-1:0] mem_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [PW:0]              raw;
    logic [PW-1:0]            rd_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
        end else if (en_i && we_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= (wr_ptr_q == PW'(NTAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    // newest slot is wr_ptr-1; bias by NTAPS so the subtraction never goes negative
    always_comb begin
        raw    = {1'b0, wr_ptr_q} + (PW + 1)'(NTAPS - 1) - {1'b0, tap_i};
        rd_idx = (raw >= (PW + 1)'(NTAPS)) ? PW'(raw - (PW + 1)'(NTAPS)) : PW'(raw);
    end

    assign rdata_o = mem_q[rd_idx];

endmodule

// File: rtl/fir_eq_core.sv
// Multi-band FIR equaliser: time-multiplexed MAC per band, per-band gain, band sum.
// Output fit is saturating when FIR_EQ_SAT_EN is defined, wrapping otherwise.
module fir_eq_core
    import fir_eq_pkg::*;
#(
    parameter int DW         = 16,
    parameter int CW         = 16,
    parameter int NTAPS      = 10,
    parameter int NBANDS     = 3,
    parameter int GW         = 8,
    parameter int GAIN_SHIFT = 7,
    parameter int OW         = 16,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        clk_en_i,
    input  logic                                        sample_valid_i,
    input  logic signed [DW-1:0]                        sample_i,
    output logic                                        sample_ready_o,
    input  logic [NBANDS*GW-1:0]                        gain_i,
    output logic [((NBANDS > 1) ? $clog2(NBANDS) : 1)-1:0] coeff_band_o,
    output logic [$clog2(NTAPS)-1:0]                    coeff_tap_o,
    input  logic signed [CW-1:0]                        coeff_i,
    output logic signed [OW-1:0]                        result_o,
    output logic                                        done_o,
    output logic                                        sat_o
);
    localparam int BANDW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
    localparam int TAPW  = $clog2(NTAPS);
    localparam int PW    = DW + CW;
    localparam int ACCW  = acc_width(DW, CW, NTAPS);
    localparam int GPW   = ACCW + GW + 1;
    localparam int TW    = total_width(DW, CW, NTAPS, GW, NBANDS);

    state_e                   state_q, state_d;
    logic [TAPW-1:0]          tap_q, tap_d;
    logic [BANDW-1:0]         band_q, band_d;
    logic [NBANDS*GW-1:0]     gain_q, gain_d;
    logic signed [DW-1:0]     xs_q, xs_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic signed [TW-1:0]     total_q, total_d;
    logic signed [OW-1:0]     result_q, result_d;
    logic                     done_q, done_d;
    logic                     sat_q, sat_d;
    logic                     accept;
    logic [DW-1:0]            ring_rd;

    logic signed [PW-1:0]     prod;
    logic [GW-1:0]            gain_sel;
    logic signed [GPW-1:0]    gprod, gterm;
    logic signed [TW-1:0]     total_nx, out_sh;
    logic signed [63:0]       sh64;

    fir_eq_ring #(.DW(DW), .NTAPS(NTAPS)) u_ring (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (clk_en_i),
        .we_i    (accept),
        .wdata_i (sample_i),
        .tap_i   (tap_q),
        .rdata_o (ring_rd)
    );

    // coeff_i pairs with xs_q: both were addressed/registered on the previous MAC edge
    assign prod     = PW'(coeff_i) * PW'(xs_q);
    assign gain_sel = gain_q[band_q*GW +: GW];
    assign gprod    = GPW'(acc_q) * GPW'($signed({1'b0, gain_sel}));
    assign gterm    = gprod >>> GAIN_SHIFT;
    assign total_nx = total_q + TW'(gterm);
    assign out_sh   = total_nx >>> OUT_SHIFT;
    assign sh64     = 64'(out_sh);

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        band_d   = band_q;
        gain_d   = gain_q;
        xs_d     = xs_q;
        acc_d    = acc_q;
        total_d  = total_q;
        result_d = result_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_valid_i) begin
                    accept  = 1'b1;
                    gain_d  = gain_i;
                    acc_d   = '0;
                    total_d = '0;
                    band_d  = '0;
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                xs_d = $signed(ring_rd);
                if (tap_q != '0) acc_d = acc_q + ACCW'(prod);
                if (tap_q == TAPW'(NTAPS - 1)) state_d = S_DRAIN;
                else                           tap_d   = tap_q + 1'b1;
            end
            S_DRAIN: begin
                acc_d   = acc_q + ACCW'(prod);
                state_d = S_GAIN;
            end
            S_GAIN: begin
                total_d = total_nx;
                acc_d   = '0;
                if (band_q == BANDW'(NBANDS - 1)) begin
                    // result registers here so done_o rises as the FSM enters OUT
                    result_d = OW'(fit_val(sh64, OW));
`ifdef FIR_EQ_SAT_EN
                    sat_d    = fit_clip(sh64, OW);
`else
                    sat_d    = 1'b0;
`endif
                    done_d   = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    band_d  = band_q + 1'b1;
                    tap_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            band_q   <= '0;
            gain_q   <= '0;
            xs_q     <= '0;
            acc_q    <= '0;
            total_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            band_q   <= band_d;
            gain_q   <= gain_d;
            xs_q     <= xs_d;
            acc_q    <= acc_d;
            total_q  <= total_d;
            result_q <= result_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
        end
    end

    assign sample_ready_o = (state_q == S_IDLE);
    assign coeff_band_o   = band_q;
    assign coeff_tap_o    = tap_q;
    assign result_o       = result_q;
    assign done_o         = done_q;
    assign sat_o          = sat_q;

endmodule

// File: tb/tb_fir_eq_core.sv
// Directed scoreboard bench: three core configurations sharing one clock.
module tb_fir_eq_core;

    typedef struct {
        int                 d;
        logic signed [15:0] r;
        logic               s;
        int                 t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    int   lat [3] = '{6, 36, 4};

    logic [2:0]         rst, en, vld;
    logic signed [15:0] smp [3];
    logic [2:0]         rdy, done, sat;
    logic signed [15:0] res [3];
    logic [7:0]         gain_a, gain_c;
    logic [23:0]        gain_b;
    logic [0:0]         band_a, band_c;
    logic [1:0]         band_b;
    logic [1:0]         tap_a;
    logic [3:0]         tap_b;
    logic [0:0]         tap_c;
    logic signed [15:0] coeff_a, coeff_b, coeff_c;
    logic signed [15:0] rom_a [4];

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous ROM models sharing each core's enable
    always @(posedge clk) if (en[0]) coeff_a <= rom_a[tap_a];
    always @(posedge clk) if (en[1]) coeff_b <= 16'sd1;
    always @(posedge clk) if (en[2]) coeff_c <= 16'sh7FFF;

    fir_eq_core #(.NTAPS(4), .NBANDS(1), .GAIN_SHIFT(0)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .clk_en_i(en[0]), .sample_valid_i(vld[0]),
        .sample_i(smp[0]), .sample_ready_o(rdy[0]), .gain_i(gain_a),
        .coeff_band_o(band_a), .coeff_tap_o(tap_a), .coeff_i(coeff_a),
        .result_o(res[0]), .done_o(done[0]), .sat_o(sat[0]));

    fir_eq_core #(.GAIN_SHIFT(0)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .clk_en_i(en[1]), .sample_valid_i(vld[1]),
        .sample_i(smp[1]), .sample_ready_o(rdy[1]), .gain_i(gain_b),
        .coeff_band_o(band_b), .coeff_tap_o(tap_b), .coeff_i(coeff_b),
        .result_o(res[1]), .done_o(done[1]), .sat_o(sat[1]));

    fir_eq_core #(.NTAPS(2), .NBANDS(1), .GAIN_SHIFT(0)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .clk_en_i(en[2]), .sample_valid_i(vld[2]),
        .sample_i(smp[2]), .sample_ready_o(rdy[2]), .gain_i(gain_c),
        .coeff_band_o(band_c), .coeff_tap_o(tap_c), .coeff_i(coeff_c),
        .result_o(res[2]), .done_o(done[2]), .sat_o(sat[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: every done pops the oldest expectation, including its arrival cycle
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_done: observed done on dut %0d, expected none", d);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("dut", 64'(d), 64'(mon_e.d));
                    chk("result", 64'(res[d]), 64'(mon_e.r));
                    chk("sat", 64'(sat[d]), 64'(mon_e.s));
                    chk("latency", 64'(cyc), 64'(mon_e.t));
                end
            end
        end
    end

    task automatic send(input int d, input logic signed [15:0] s, input bit push,
                        input logic signed [15:0] r, input logic se, input int extra);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!(rdy[d] && en[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 200), 64'(1));
        vld[d] = 1'b1;
        smp[d] = s;
        if (push) begin
            e.d = d; e.r = r; e.s = se; e.t = cyc + 1 + lat[d] + extra;
            sbq.push_back(e);
        end
        @(negedge clk);
        vld[d] = 1'b0;
        smp[d] = 16'($urandom_range(0, 65535));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sbq.size()), 64'(0));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 3'b111; en = 3'b111; vld = 3'b000;
        for (int i = 0; i < 3; i++) smp[i] = 16'sd0;
        gain_a = 8'd1; gain_b = {8'd3, 8'd2, 8'd1}; gain_c = 8'd1;
        rom_a = '{16'sd4, 16'sd1, 16'sd2, 16'sd1};

        repeat (2) @(negedge clk);
        rst = 3'b000;
        chk("rst_ready_a", 64'(rdy[0]), 64'(1));
        chk("rst_done_a", 64'(done[0]), 64'(0));
        chk("rst_result_a", 64'(res[0]), 64'(0));
        chk("rst_sat_a", 64'(sat[0]), 64'(0));
        chk("rst_band_a", 64'(band_a), 64'(0));
        chk("rst_tap_a", 64'(tap_a), 64'(0));
        chk("rst_ready_b", 64'(rdy[1]), 64'(1));
        chk("rst_done_b", 64'(done[1]), 64'(0));
        chk("rst_result_b", 64'(res[1]), 64'(0));
        chk("rst_band_b", 64'(band_b), 64'(0));
        chk("rst_tap_b", 64'(tap_b), 64'(0));

        // impulse response
        send(0, 16'sd1, 1, 16'sd4, 1'b0, 0);
        send(0, 16'sd0, 1, 16'sd1, 1'b0, 0);
        send(0, 16'sd0, 1, 16'sd2, 1'b0, 0);
        send(0, 16'sd0, 1, 16'sd1, 1'b0, 0);
        drain();

        // ring wrap, moving sum of four
        rom_a = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        send(0, 16'sd5, 1, 16'sd5, 1'b0, 0);
        send(0, 16'sd2, 1, 16'sd7, 1'b0, 0);
        send(0, 16'sd3, 1, 16'sd10, 1'b0, 0);
        send(0, 16'sd4, 1, 16'sd14, 1'b0, 0);
        send(0, 16'sd1, 1, 16'sd10, 1'b0, 0);
        drain();

        // stall mid-MAC: window {0,1,4,3}, gain change while busy is ignored
        send(0, 16'sd0, 1, 16'sd8, 1'b0, 5);
        @(negedge clk);
        en[0] = 1'b0;
        gain_a = 8'd7;
        repeat (5) @(negedge clk);
        en[0] = 1'b1;
        drain();
        gain_a = 8'd1;

        // abort mid-MAC: no done, history discarded
        rom_a = '{16'sd4, 16'sd1, 16'sd2, 16'sd1};
        send(0, 16'sd9, 0, 16'sd0, 1'b0, 0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_result", 64'(res[0]), 64'(0));
        chk("abort_ready", 64'(rdy[0]), 64'(1));
        chk("abort_tap", 64'(tap_a), 64'(0));
        send(0, 16'sd1, 1, 16'sd4, 1'b0, 0);
        drain();

        // multi-band gain sum
        send(1, 16'sd100, 1, 16'sd600, 1'b0, 0);
        drain();

        // output fit boundary
`ifdef FIR_EQ_SAT_EN
        send(2, 16'sh7FFF, 1, 16'sh7FFF, 1'b1, 0);
        send(2, 16'sh7FFF, 1, 16'sh7FFF, 1'b1, 0);
`else
        send(2, 16'sh7FFF, 1, 16'sh0001, 1'b0, 0);
        send(2, 16'sh7FFF, 1, 16'sh0002, 1'b0, 0);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_eq_core.md
# fir_eq_core

Parametrised multi-band FIR equaliser core: accepts one signed audio sample per handshake and stores it in an internal circular window. It runs a time-multiplexed multiply-accumulate over NTAPS coefficients for each of NBANDS bands, scales each band by a per-band gain, sums the bands and emits one output sample with a done pulse. It sits between the sample-window/input path and the output serialiser, and it reads coefficients from an external synchronous coefficient ROM.

## Interface
- DW, 16, sample width (signed)
- CW, 16, coefficient width (signed)
- NTAPS, 10, taps per band (≥2)
- NBANDS, 3, band count (≥1)
- GW, 8, per-band gain width (unsigned)
- GAIN_SHIFT, 7, arithmetic right shift applied after each gain multiply
- OW, 16, output width (signed)
- OUT_SHIFT, 0, arithmetic right shift applied to the band sum before output
- clk_i  in  1  clock; one clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- clk_en_i  in  1  global enable; when low all state freezes
- sample_valid_i  in  1  sample offered
- sample_i  in  DW  signed input sample
- sample_ready_o  out  1  core can accept a sample
- gain_i  in  NBANDS*GW  per-band gains; band b occupies bits [b*GW +: GW]
- coeff_band_o  out  max(1,$clog2(NBANDS))  ROM band address
- coeff_tap_o  out  $clog2(NTAPS)  ROM tap address
- coeff_i  in  CW  ROM data; valid one enabled cycle after the address
- result_o  out  OW  filtered output; registered; holds until next done
- done_o  out  1  one-enabled-cycle pulse when result_o updates
- sat_o  out  1  result_o was clipped (registered with result_o)

## Operation
- States: IDLE, MAC, DRAIN, GAIN, OUT.
- IDLE: sample_ready_o=1. Acceptance requires sample_valid_i && sample_ready_o && clk_en_i. On acceptance:
  - write the sample to the ring at wr_ptr and advance wr_ptr modulo NTAPS;
  - latch gain_i; clear band_acc and total; set band=0, tap=0; go to MAC.
- MAC, one cycle per tap:
  - drive coeff_band_o=band, coeff_tap_o=tap;
  - register x[n−tap] = ring[(newest − tap) mod NTAPS];
  - from the second MAC cycle on, band_acc += coeff_i × registered sample from the previous cycle;
  - after tap NTAPS−1, go to DRAIN.
- DRAIN: accumulate the final product, then go to GAIN.
- GAIN: total += (band_acc × gain[band]) >>> GAIN_SHIFT; clear band_acc. If band < NBANDS−1: band++, tap=0, go to MAC. Otherwise go to OUT.
- OUT: result_o = fit(total >>> OUT_SHIFT); done_o=1; next state IDLE.
- Widths:
  - products are DW+CW bits;
  - band_acc is ACCW = DW+CW+$clog2(NTAPS) bits;
  - the gain product is ACCW+GW+1 bits (gain zero-extended, signed multiply);
  - total adds $clog2(NBANDS)+1 bits;
  - no internal overflow is possible.
- `>>>` is an arithmetic shift (floor).
- Ring contents reset to 0, so the first NTAPS−1 outputs see zero history.
- wr_ptr wraps NTAPS−1 → 0. Tap indexing wraps identically.
- gain_i and sample_i changes outside acceptance have no effect.

## Timing
- Reset values:
  - state IDLE; sample_ready_o=1;
  - result_o=0, done_o=0, sat_o=0;
  - coeff_band_o=0, coeff_tap_o=0;
  - ring, accumulators and wr_ptr all 0.
- Reset asserted mid-operation:
  - abort, return to the reset values above;
  - no done_o for the aborted sample; ring history is discarded.
- Latency:
  - count enabled cycles from the cycle after the acceptance edge, starting at index 0;
  - done_o is high at index L = NBANDS*(NTAPS+2); with defaults L=36;
  - sample_ready_o returns high at index L+1.
- Throughput: one sample per L+1 enabled cycles.
- clk_en_i low:
  - every register holds, including done_o, the coefficient address and the ROM-pipeline sample register;
  - the core assumes coeff_i is held by the ROM while clk_en_i is low (the ROM shares the enable);
  - no sample is accepted.
- rst_i has priority over clk_en_i.

## Configuration
- FIR_EQ_SAT_EN defined:
  - fit() clips to [−2^(OW−1), 2^(OW−1)−1];
  - sat_o=1 on the done cycle if clipping occurred, 0 otherwise.
- FIR_EQ_SAT_EN undefined:
  - fit() takes the low OW bits (two's-complement wrap);
  - sat_o is tied 0.

## Structure
- Package fir_eq_pkg holds:
  - state enum typedef;
  - width localparam functions (ACCW, total width);
  - fit/saturate function.
- Sub-module fir_eq_ring: NTAPS×DW circular buffer with write port, wr_ptr, tap-offset read and synchronous reset to zero.
- fir_eq_core contains the FSM, counters, MAC datapath and output register.

## Test plan
- Reset: hold rst_i 2 cycles → result_o=0, done_o=0, sat_o=0, sample_ready_o=1, coeff addresses 0.
- Impulse response:
  - configuration NBANDS=1, NTAPS=4, coeffs {4,1,2,1}, gain=1, GAIN_SHIFT=0;
  - stimulus: samples 1,0,0,0 → results 4,1,2,1;
  - done_o at index 6 after each acceptance.
- Ring wrap, same configuration with coeffs all 1:
  - stimulus: samples 5,2,3,4,1;
  - required results: 5, 7, 10, 14, 10 (the oldest sample is dropped after wrap).
- Multi-band gain:
  - configuration: defaults, coeffs all 1, gains {1,2,3}, GAIN_SHIFT=0;
  - stimulus: single sample 100 → result 600, done_o at index 36.
- Saturation:
  - configuration NBANDS=1, NTAPS=2, GAIN_SHIFT=0, gain=1, coeffs 0x7FFF;
  - stimulus: samples 0x7FFF, 0x7FFF;
  - with FIR_EQ_SAT_EN: second result 0x7FFF, sat_o=1;
  - without FIR_EQ_SAT_EN: second result 0x0002, sat_o=0.
- Stall and abort:
  - drop clk_en_i for 5 cycles mid-MAC → same result, done_o delayed by exactly 5 cycles;
  - pulse rst_i mid-MAC → no done_o for that sample; the next sample 1 with coeffs {4,1,2,1} yields 4.
